// File: rtl/int_div_8.sv
// int_div_8 : iterative unsigned 16/8 divider (restoring shift/subtract).
//   quotient  = dividend / divisor  (16 bits)
//   remainder = dividend % divisor  (8 bits)
// One quotient bit is produced per clock, so a normal division takes
// 16 BUSY cycles. Operands arrive on an in_valid/in_ready handshake and
// results leave on an out_valid/out_ready handshake.
//
// Handshake rule (both sides): a transfer happens on a rising clock edge
// where valid and ready are both 1. The producer holds its data stable
// while valid=1 and ready=0. A ready/valid seen outside that edge means
// nothing.
//
// A zero divisor never enters BUSY. The result is quotient=16'hFFFF,
// remainder=dividend[7:0] and div_by_zero=1, and it is ready one edge
// after accept.
//
// Optional build macro: INT_DIV_8_SHORTCUT_EN
//   When defined, a nonzero divisor larger than the dividend also skips
//   BUSY and returns quotient=0, remainder=dividend[7:0] one edge after
//   accept. Results are the same either way; only latency changes.
//
// o_dbg_state exposes the FSM state so that checkers can bind to it.
module int_div_8 (
  input  logic        clk,
  input  logic        reset,        // asynchronous, active-low
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] dividend,
  input  logic [7:0]  divisor,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] quotient,
  output logic [7:0]  remainder,
  output logic        div_by_zero,
  output logic [1:0]  o_dbg_state
);

  // One iteration per dividend bit. This value is fixed by the datapath
  // width and is not meant to be overridden.
  localparam int         N_ITER    = 16;
  localparam logic [3:0] CNT_START = 4'(N_ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_in_ready;
  logic        r_out_valid;
  logic [15:0] r_work_q;     // dividend shifting out, quotient shifting in
  logic [7:0]  r_prem;       // partial remainder; always < divisor between steps
  logic [7:0]  r_divisor;
  logic [3:0]  r_cnt;
  logic [15:0] r_quot;
  logic [7:0]  r_rem;
  logic        r_dbz;

  logic        w_accept;
  logic        w_handoff;
  logic        w_div_zero;
  logic        w_shortcut;
  logic        w_last;
  logic [8:0]  w_shift_rem;
  logic        w_ge;
  logic [7:0]  w_step_rem;
  logic [15:0] w_step_q;

  // An operand transfers only when the block itself is advertising ready.
  assign w_accept   = in_valid & r_in_ready;
  assign w_handoff  = r_out_valid & out_ready;
  assign w_div_zero = (divisor == 8'd0);
  assign w_last     = (r_cnt == 4'd0);

`ifdef INT_DIV_8_SHORTCUT_EN
  // A nonzero divisor larger than the dividend gives quotient 0 with
  // nothing left to iterate. The compare is done on zero-extended values.
  assign w_shortcut = !w_div_zero && ({8'd0, divisor} > dividend);
`else
  assign w_shortcut = 1'b0;
`endif

  // Restoring step. Shift {partial_rem, work_q} left by one bit. The
  // shifted remainder needs 9 bits: the stored remainder is below
  // divisor <= 255, and after doubling plus one it can reach 509.
  // When the compare succeeds the true difference is below the divisor,
  // so an 8-bit subtract of the low byte gives the exact result.
  assign w_shift_rem = {r_prem, r_work_q[15]};
  assign w_ge        = (w_shift_rem >= {1'b0, r_divisor});
  assign w_step_rem  = w_ge ? (w_shift_rem[7:0] - r_divisor) : w_shift_rem[7:0];
  assign w_step_q    = {r_work_q[14:0], w_ge};

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_div_zero || w_shortcut) begin
            w_next_state = S_DONE;
          end else begin
            w_next_state = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        if (w_handoff) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Datapath and registered handshake outputs. in_ready and out_valid
  // follow the next state, so each one matches the state register. The
  // one exception is in_ready: it is held low during reset and rises one
  // edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_work_q    <= 16'd0;
      r_prem      <= 8'd0;
      r_divisor   <= 8'd0;
      r_cnt       <= 4'd0;
      r_quot      <= 16'd0;
      r_rem       <= 8'd0;
      r_dbz       <= 1'b0;
    end else begin
      r_in_ready  <= (w_next_state == S_IDLE);
      r_out_valid <= (w_next_state == S_DONE);
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_divisor <= divisor;
            if (w_div_zero) begin
              r_quot <= 16'hFFFF;
              r_rem  <= dividend[7:0];
              r_dbz  <= 1'b1;
            end else if (w_shortcut) begin
              r_quot <= 16'd0;
              r_rem  <= dividend[7:0];
              r_dbz  <= 1'b0;
            end else begin
              r_work_q <= dividend;
              r_prem   <= 8'd0;
              r_cnt    <= CNT_START;
            end
          end
        end
        S_BUSY: begin
          r_work_q <= w_step_q;
          r_prem   <= w_step_rem;
          r_cnt    <= r_cnt - 4'd1;
          if (w_last) begin
            r_quot <= w_step_q;
            r_rem  <= w_step_rem;
            r_dbz  <= 1'b0;
          end
        end
        default: begin
          // DONE: results stay where they are until the handoff edge,
          // and they are still held afterwards.
        end
      endcase
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = r_out_valid;
  assign quotient    = r_quot;
  assign remainder   = r_rem;
  assign div_by_zero = r_dbz;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_int_div_8.sv
// Directed bench for int_div_8. Expected values below are worked out by hand.
module tb_int_div_8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;
  logic [1:0]  dbg_state;

  int n_total = 0;
  int n_bad   = 0;

`ifdef INT_DIV_8_SHORTCUT_EN
  localparam int SHORT_LAT = 1;
`else
  localparam int SHORT_LAT = 17;
`endif

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int_div_8 dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .o_dbg_state (dbg_state)
  );

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Waits for in_ready, presents one operand pair, and returns at the
  // falling edge just after the accept edge T.
  task automatic send(input logic [15:0] a, input logic [7:0] b);
    int guard;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("send_timeout", 32'd1, 32'd0);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the falling edge after the accept edge. Latency is the number
  // of falling edges, counting this one, up to the first one with out_valid
  // high: 1 for a fast path and 17 for the full path. If out_ready is high,
  // it also checks the handoff.
  task automatic expect_result(input string tag, input logic [15:0] eq, input logic [7:0] er,
                               input logic ez, input int elat);
    int  cyc;
    logic rdy_seen;
    cyc = 1;
    rdy_seen = 1'b0;
    while (!out_valid && cyc < 40) begin
      rdy_seen = rdy_seen | in_ready;
      @(negedge clk);
      cyc++;
    end
    check({tag, "_lat"}, cyc, elat);
    check({tag, "_rdy_busy"}, {31'd0, rdy_seen}, 32'd0);
    check({tag, "_q"}, {16'd0, quotient}, {16'd0, eq});
    check({tag, "_r"}, {24'd0, remainder}, {24'd0, er});
    check({tag, "_dbz"}, {31'd0, div_by_zero}, {31'd0, ez});
    check({tag, "_rdy_done"}, {31'd0, in_ready}, 32'd0);
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_ov_drop"}, {31'd0, out_valid}, 32'd0);
      check({tag, "_rdy_back"}, {31'd0, in_ready}, 32'd1);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    dividend  = 16'd0;
    divisor   = 8'd0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_q", {16'd0, quotient}, 32'd0);
    check("rst_r", {24'd0, remainder}, 32'd0);
    check("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("rel_in_ready", {31'd0, in_ready}, 32'd1);

    send(16'd1000, 8'd7);
    expect_result("d1000_7", 16'd142, 8'd6, 1'b0, 17);
    send(16'hFFFF, 8'hFF);
    expect_result("ffff_ff", 16'd257, 8'd0, 1'b0, 17);
    send(16'hFFFF, 8'h01);
    expect_result("ffff_01", 16'd65535, 8'd0, 1'b0, 17);
    send(16'h00FF, 8'h10);
    expect_result("00ff_10", 16'd15, 8'd15, 1'b0, 17);
    send(16'd5, 8'd0);
    expect_result("d5_0", 16'hFFFF, 8'd5, 1'b1, 1);
    send(16'd20, 8'd4);
    expect_result("d20_4", 16'd5, 8'd0, 1'b0, 17);
    send(16'h1234, 8'd0);
    expect_result("d1234_0", 16'hFFFF, 8'h34, 1'b1, 1);
    send(16'd3, 8'd200);
    expect_result("d3_200", 16'd0, 8'd3, 1'b0, SHORT_LAT);

    // Backpressure: the result must stay put and new operands must be ignored.
    out_ready = 1'b0;
    send(16'd1000, 8'd7);
    expect_result("bp", 16'd142, 8'd6, 1'b0, 17);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      dividend = 16'd50;
      divisor  = 8'd5;
      @(negedge clk);
      check("bp_hold_ov", {31'd0, out_valid}, 32'd1);
      check("bp_hold_q", {16'd0, quotient}, 32'd142);
      check("bp_hold_r", {24'd0, remainder}, 32'd6);
      check("bp_hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_handoff_ov", {31'd0, out_valid}, 32'd0);
    check("bp_handoff_rdy", {31'd0, in_ready}, 32'd1);
    check("bp_handoff_q", {16'd0, quotient}, 32'd142);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_accept_rdy", {31'd0, in_ready}, 32'd0);
    expect_result("bp_next", 16'd10, 8'd0, 1'b0, 17);

    // Reset in the middle of a division, before iteration 8 at edge T+8.
    send(16'd40000, 8'd123);
    repeat (7) @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("mid_rst_q", {16'd0, quotient}, 32'd0);
    check("mid_rst_r", {24'd0, remainder}, 32'd0);
    check("mid_rst_dbz", {31'd0, div_by_zero}, 32'd0);
    check("mid_rst_ov", {31'd0, out_valid}, 32'd0);
    check("mid_rst_rdy", {31'd0, in_ready}, 32'd0);
    check("mid_rst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("mid_rel_rdy", {31'd0, in_ready}, 32'd1);
    send(16'd40000, 8'd123);
    expect_result("d40000_123", 16'd325, 8'd25, 1'b0, 17);

    // ---------------- report ----------------
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/int_div_8.md
Name: int_div_8

Overview:
Iterative unsigned integer divider, the inverse operation of the team's registered 8-bit multiplier.
- Divides a 16-bit dividend by an 8-bit divisor.
- Produces a 16-bit quotient and an 8-bit remainder.
- Restoring shift/subtract, one quotient bit per clock, valid/ready handshakes on both sides.
- Used by display/arith IP to recover operands from products, e.g. for checking multiplier results.

Parameters:
- N_ITER, 16, number of iterations; fixed equal to the dividend width; not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- in_valid  input  1  dividend/divisor present
- in_ready  output  1  block can accept operands
- dividend  input  16  unsigned dividend
- divisor  input  8  unsigned divisor
- out_valid  output  1  result available
- out_ready  input  1  consumer takes result
- quotient  output  16  unsigned quotient
- remainder  output  8  unsigned remainder
- div_by_zero  output  1  result came from a zero divisor

Behaviour:
- Reset asserted (reset=0), async:
  - state = IDLE; iteration counter = 0.
  - quotient = 0, remainder = 0, div_by_zero = 0, out_valid = 0.
  - in_ready = 1 once reset is released.
- Reset mid-operation aborts the division; the result is discarded.
- All outputs are registered. in_ready = (state == IDLE); out_valid = (state == DONE).
- States:
  - IDLE: on in_valid & in_ready at edge T, capture operands.
    - If divisor == 0: go to DONE at edge T with quotient = 16'hFFFF, remainder = dividend[7:0], div_by_zero = 1.
    - Else: go to BUSY; working quotient = dividend; 9-bit partial remainder = 0; counter = 15.
  - BUSY: each edge does one restoring step.
    - Shift {partial_rem, work_q} left 1.
    - If shifted partial_rem >= divisor: subtract divisor and set the new quotient LSB to 1; else LSB = 0.
    - The partial remainder is 9 bits wide so the compare never overflows.
    - Counter decrements; on the step with counter == 0, load the quotient/remainder outputs, clear div_by_zero, go to DONE.
    - Iteration edges are T+1 .. T+16; out_valid is first high in the cycle after edge T+16.
  - DONE: hold quotient/remainder/div_by_zero stable while out_valid=1 and out_ready=0.
    - On out_valid & out_ready at an edge: go to IDLE; outputs keep their values, out_valid drops.
- Back-to-back operation: a new operand is not accepted in the same edge as result handoff, because in_ready=0 in DONE. Minimum accept-to-accept spacing is 18 edges.
- in_valid in BUSY or DONE is ignored. The operand must be held by the producer until in_ready.
- Invariant for every nonzero divisor: dividend == quotient*divisor + remainder, with remainder < divisor.

Optional Feature:
- Macro: INT_DIV_8_SHORTCUT_EN
- Defined: in IDLE, an accepted operand with nonzero divisor and dividend < divisor (zero-extended compare) goes directly to DONE at edge T.
  - quotient = 0, remainder = dividend[7:0], div_by_zero = 0.
  - Latency is the same as the divide-by-zero path.
- Not defined: such operands run the full 16-iteration BUSY path. Results are identical; only latency differs.
- The divide-by-zero fast path exists in both builds.

Test Plan:
- Reset then 1000/7 with out_ready=1 -> quotient=142, remainder=6, div_by_zero=0; out_valid first high after the 16th edge following accept; in_ready=0 until the handoff edge.
- 16'hFFFF/8'hFF and 16'hFFFF/8'h01 -> 257 r 0 and 65535 r 0; 16'h00FF/8'h10 -> 15 r 15.
- 5/0 -> quotient=16'hFFFF, remainder=5, div_by_zero=1 after edge T; next 20/4 -> 5 r 0 with div_by_zero=0.
- 3/200 -> 0 r 3. With INT_DIV_8_SHORTCUT_EN, out_valid is high after edge T; without it, after T+16.
- Backpressure: out_ready=0 for 10 cycles after 1000/7 completes -> outputs stable, out_valid held, in_valid with new operands ignored. Then out_ready=1 -> handoff, IDLE, new operand accepted the following edge.
- Assert reset at iteration 8 of 40000/123 -> all outputs 0 immediately (async). After release, 40000/123 -> 325 r 25.
